// File: rtl/settings_pkg.sv
// Shared build settings for the moving-sum block: default sample width, channel count and window.
package settings_pkg;
   localparam int DATA_SIZE    = 16;
   localparam int NUM_CHANNELS = 4;
   localparam int WINDOW       = 16;

   // Width that holds the sum of WINDOW signed samples without overflow.
   function automatic int full_size(input int data_size, input int window);
      return data_size + $clog2(window);
   endfunction
endpackage

// File: rtl/template_delay_ram.sv
// Per-channel delay lines in one simple dual-port memory.
// Read is synchronous and read-before-write; the whole port stalls while enable is low.
module template_delay_ram #(
   parameter int DATA_SIZE = settings_pkg::DATA_SIZE,
   parameter int ADDR_W    = 6
) (
   input  logic                 clk,
   input  logic                 enable,
   input  logic                 write,
   input  logic [ADDR_W-1:0]    write_addr,
   input  logic [DATA_SIZE-1:0] write_data,
   input  logic [ADDR_W-1:0]    read_addr,
   output logic [DATA_SIZE-1:0] read_data
);
   logic [DATA_SIZE-1:0] mem_r [1 << ADDR_W];

   // Storage is never cleared: fill counts in the parent mask stale entries.
   always_ff @(posedge clk) begin
      if (enable) begin
         read_data <= mem_r[read_addr];
         if (write) begin
            mem_r[write_addr] <= write_data;
         end
      end
   end
endmodule

// File: rtl/template_moving_sum.sv
// Time-interleaved per-channel moving sum over WINDOW samples, 2-stage pipeline with stall.
// Define TEMPLATE_MOVING_AVERAGE_EN to output the floored average instead of the raw sum.
module template_moving_sum #(
   parameter int  DATA_SIZE    = settings_pkg::DATA_SIZE,
   parameter int  NUM_CHANNELS = settings_pkg::NUM_CHANNELS,
   parameter int  WINDOW       = settings_pkg::WINDOW,
   localparam int FULL_SIZE    = settings_pkg::full_size(DATA_SIZE, WINDOW),
   localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic signed [DATA_SIZE-1:0] input_data,
   input  logic                        enable,
   output logic                        input_ready,
   input  logic                        output_ready,
   output logic signed [FULL_SIZE-1:0] output_data,
   output logic                        output_data_valid,
   output logic [CH_W-1:0]             output_channel
);
   localparam int PTR_W  = $clog2(WINDOW);
   localparam int ADDR_W = CH_W + PTR_W;
   localparam int NCH    = 1 << CH_W;
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CHANNELS - 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WINDOW - 1);
   localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(WINDOW);

   logic                        flush_s;
   logic                        advance_s;
   logic                        accept_s;
   logic [CH_W-1:0]             ch_r;
   logic [PTR_W-1:0]            wptr_r [NCH];
   logic [PTR_W:0]              fill_r [NCH];
   logic signed [FULL_SIZE-1:0] sum_r  [NCH];

   logic                        s1_valid_r;
   logic signed [DATA_SIZE-1:0] s1_data_r;
   logic [CH_W-1:0]             s1_ch_r;
   logic                        s1_full_r;
   logic [DATA_SIZE-1:0]        ram_rd_s;

   logic signed [FULL_SIZE-1:0] x_ext_s;
   logic signed [FULL_SIZE-1:0] oldest_s;
   logic signed [FULL_SIZE-1:0] new_sum_s;
   logic signed [FULL_SIZE-1:0] result_s;

   logic                        out_valid_r;
   logic signed [FULL_SIZE-1:0] out_data_r;
   logic [CH_W-1:0]             out_ch_r;

   assign flush_s     = reset | clear;
   assign advance_s   = ~out_valid_r | output_ready;
   assign accept_s    = enable & advance_s & ~flush_s;
   assign input_ready = advance_s;

   template_delay_ram #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_W    (ADDR_W)
   ) u_delay_ram (
      .clk        (clk),
      .enable     (advance_s),
      .write      (accept_s),
      .write_addr ({ch_r, wptr_r[ch_r]}),
      .write_data (input_data),
      .read_addr  ({ch_r, wptr_r[ch_r]}),
      .read_data  (ram_rd_s)
   );

   // Stage-2 arithmetic: drop the sample leaving the window once the channel is full.
   always_comb begin
      x_ext_s  = {{PTR_W{s1_data_r[DATA_SIZE-1]}}, s1_data_r};
      oldest_s = '0;
      if (s1_full_r) begin
         oldest_s = {{PTR_W{ram_rd_s[DATA_SIZE-1]}}, ram_rd_s};
      end else begin
         oldest_s = '0;
      end
      new_sum_s = sum_r[s1_ch_r] + x_ext_s - oldest_s;
`ifdef TEMPLATE_MOVING_AVERAGE_EN
      result_s = new_sum_s >>> PTR_W;
`else
      result_s = new_sum_s;
`endif
   end

   // Stage 1: capture sample and channel, advance round-robin counter, pointers and fill counts.
   always_ff @(posedge clk) begin
      if (flush_s) begin
         ch_r       <= '0;
         s1_valid_r <= 1'b0;
         s1_data_r  <= '0;
         s1_ch_r    <= '0;
         s1_full_r  <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            wptr_r[c] <= '0;
            fill_r[c] <= '0;
         end
      end else if (advance_s) begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_data_r    <= input_data;
            s1_ch_r      <= ch_r;
            s1_full_r    <= (fill_r[ch_r] == FILL_FULL);
            wptr_r[ch_r] <= (wptr_r[ch_r] == PTR_LAST) ? '0 : wptr_r[ch_r] + 1'b1;
            if (fill_r[ch_r] != FILL_FULL) begin
               fill_r[ch_r] <= fill_r[ch_r] + 1'b1;
            end
            ch_r <= (ch_r == CH_LAST) ? '0 : ch_r + 1'b1;
         end
      end
   end

   // Stage 2: commit the running sum and load the output register.
   always_ff @(posedge clk) begin
      if (flush_s) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_ch_r    <= '0;
         for (int c = 0; c < NCH; c++) begin
            sum_r[c] <= '0;
         end
      end else if (advance_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            sum_r[s1_ch_r] <= new_sum_s;
            out_data_r     <= result_s;
            out_ch_r       <= s1_ch_r;
         end
      end
   end

   assign output_data       = out_data_r;
   assign output_data_valid = out_valid_r;
   assign output_channel    = out_ch_r;
endmodule

// File: tb/tb_template_moving_sum.sv
// Self-checking bench: a default 4x16 instance and a 1-channel, WINDOW=4 instance with a scoreboard each.
module tb_template_moving_sum;
`ifdef TEMPLATE_MOVING_AVERAGE_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic signed [15:0] a_data = 16'sd0;
   logic signed [15:0] b_data = 16'sd0;
   logic a_en = 1'b0, b_en = 1'b0, a_ordy = 1'b1, b_ordy = 1'b1;
   logic a_irdy, b_irdy, a_valid, b_valid;
   logic signed [19:0] a_out;
   logic signed [17:0] b_out;
   logic [1:0] a_ch;
   logic [0:0] b_ch;

   int checks = 0;
   int errors = 0;
   typedef struct { int ch; longint val; } exp_t;
   exp_t   sb_a[$];
   exp_t   sb_b[$];
   longint hist_a[4][$];
   longint hist_b[$];
   int     ch_model = 0;
   logic   a_took = 1'b0;
   longint held;

   always #5 clk = ~clk;

   template_moving_sum dut_a (
      .clk(clk), .reset(reset), .clear(clear), .input_data(a_data), .enable(a_en),
      .input_ready(a_irdy), .output_ready(a_ordy), .output_data(a_out),
      .output_data_valid(a_valid), .output_channel(a_ch)
   );

   template_moving_sum #(.DATA_SIZE(16), .NUM_CHANNELS(1), .WINDOW(4)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .input_data(b_data), .enable(b_en),
      .input_ready(b_irdy), .output_ready(b_ordy), .output_data(b_out),
      .output_data_valid(b_valid), .output_channel(b_ch)
   );

   function automatic longint model_out(longint s, int lg);
      return AVG ? (s >>> lg) : s;
   endfunction

   function automatic longint wsum(longint q[$]);
      longint t = 0;
      foreach (q[i]) t += q[i];
      return t;
   endfunction

   task automatic chk(string tag, longint got, longint exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Monitor both DUTs at the falling edge, then advance to just after the next rising edge.
   task automatic step;
      exp_t e;
      @(negedge clk);
      if (a_valid && a_ordy && !reset && !clear) begin
         checks++;
         assert (sb_a.size() != 0) else begin
            errors++;
            $error("FAIL a_extra got=%0d exp=none", a_out);
         end
         if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            chk("a_sb_data", longint'(a_out), e.val);
            chk("a_sb_ch", longint'(a_ch), longint'(e.ch));
         end
      end
      if (b_valid && b_ordy && !reset && !clear) begin
         checks++;
         assert (sb_b.size() != 0) else begin
            errors++;
            $error("FAIL b_extra got=%0d exp=none", b_out);
         end
         if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            chk("b_sb_data", longint'(b_out), e.val);
            chk("b_sb_ch", longint'(b_ch), longint'(e.ch));
         end
      end
      a_took = a_en && a_irdy && !reset && !clear;
      if (reset || clear) begin
         sb_a.delete();
         sb_b.delete();
         for (int c = 0; c < 4; c++) hist_a[c].delete();
         hist_b.delete();
         ch_model = 0;
      end else begin
         if (a_took) begin
            hist_a[ch_model].push_back(longint'(a_data));
            if (hist_a[ch_model].size() > 16) void'(hist_a[ch_model].pop_front());
            e.ch  = ch_model;
            e.val = model_out(wsum(hist_a[ch_model]), 4);
            sb_a.push_back(e);
            ch_model = (ch_model + 1) % 4;
         end
         if (b_en && b_irdy) begin
            hist_b.push_back(longint'(b_data));
            if (hist_b.size() > 4) void'(hist_b.pop_front());
            e.ch  = 0;
            e.val = model_out(wsum(hist_b), 2);
            sb_b.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      step; step; step;
      chk("rst_valid", longint'(a_valid), 64'sd0);
      chk("rst_data", longint'(a_out), 64'sd0);
      chk("rst_ch", longint'(a_ch), 64'sd0);
      chk("rst_irdy", longint'(a_irdy), 64'sd1);
      chk("rst_b_valid", longint'(b_valid), 64'sd0);
      reset = 1'b0;

      // Counting stream on A, constant full-scale negative on B.
      a_en = 1'b1; a_data = 16'sd1; b_en = 1'b1; b_data = 16'sh8000;
      step;
      chk("lat_s1_valid", longint'(a_valid), 64'sd0);
      a_data = 16'sd2;
      step;
      chk("lat_valid", longint'(a_valid), 64'sd1);
      chk("lat_data", longint'(a_out), model_out(64'sd1, 4));
      chk("lat_ch", longint'(a_ch), 64'sd0);
      for (int i = 3; i <= 80; i++) begin
         a_data = 16'(i);
         b_en   = (i <= 10);
         step;
      end
      a_en = 1'b0; b_en = 1'b0;
      step; step; step;
      chk("a_full_sum", longint'(a_out), model_out(64'sd800, 4));
      chk("a_full_ch", longint'(a_ch), 64'sd3);
      chk("b_held_sum", longint'(b_out), model_out(-64'sd131072, 2));

      // Stall with enable held high.
      a_en = 1'b1; a_data = 16'sd200;
      for (int k = 0; k < 3; k++) begin
         step;
         if (a_took) a_data = a_data + 16'sd1;
      end
      a_ordy = 1'b0;
      #1;
      chk("stall_irdy_first", longint'(a_irdy), 64'sd0);
      held = longint'(a_out);
      for (int k = 0; k < 5; k++) begin
         step;
         if (a_took) a_data = a_data + 16'sd1;
         chk("stall_hold_data", longint'(a_out), held);
         chk("stall_hold_valid", longint'(a_valid), 64'sd1);
         chk("stall_irdy", longint'(a_irdy), 64'sd0);
      end
      a_ordy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step;
         if (a_took) a_data = a_data + 16'sd1;
      end
      a_en = 1'b0;
      step; step; step;
      chk("stall_sb_empty", longint'(sb_a.size()), 64'sd0);

      // Clear mid-stream; the sample presented with clear is discarded.
      a_en = 1'b1; a_data = 16'sd1;
      for (int k = 0; k < 7; k++) begin
         step;
         a_data = a_data + 16'sd1;
      end
      clear = 1'b1; a_data = 16'sd999; b_en = 1'b1; b_data = 16'sd5;
      step;
      clear = 1'b0; b_en = 1'b0;
      chk("clr_drop", longint'(a_valid), 64'sd0);
      a_data = 16'sd50;
      step;
      a_en = 1'b0;
      step;
      chk("clr_valid", longint'(a_valid), 64'sd1);
      chk("clr_data", longint'(a_out), model_out(64'sd50, 4));
      chk("clr_ch", longint'(a_ch), 64'sd0);
      chk("clr_b_drop", longint'(b_valid), 64'sd0);

      // Floor behaviour on one channel: -1,0,0,0.
      b_en = 1'b1; b_data = 16'shFFFF;
      step;
      b_data = 16'sd0;
      step; step; step;
      b_en = 1'b0;
      step; step;
      chk("floor_last", longint'(b_out), model_out(-64'sd1, 2));

      // Reset while an output is held.
      a_en = 1'b1; a_data = 16'sd77; a_ordy = 1'b0;
      step;
      a_en = 1'b0;
      step; step;
      chk("held_valid", longint'(a_valid), 64'sd1);
      chk("held_data", longint'(a_out), model_out(64'sd77, 4));
      reset = 1'b1;
      step;
      reset = 1'b0;
      chk("rst_hold_valid", longint'(a_valid), 64'sd0);
      chk("rst_hold_data", longint'(a_out), 64'sd0);
      chk("rst_hold_ch", longint'(a_ch), 64'sd0);
      a_ordy = 1'b1;
      step; step;
      chk("end_sb_a_empty", longint'(sb_a.size()), 64'sd0);
      chk("end_sb_b_empty", longint'(sb_b.size()), 64'sd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/template_moving_sum.md
TEMPLATE_MOVING_SUM -- requirements
Module: template_moving_sum

Interface
REQ-001 The module SHALL take parameter DATA_SIZE, default settings_pkg::DATA_SIZE (16): signed input sample width.
REQ-002 The module SHALL take parameter NUM_CHANNELS, default 4: number of time-interleaved channels, legal range 1..64.
REQ-003 The module SHALL take parameter WINDOW, default 16: samples summed per channel, a power of two, legal range 2..1024.
REQ-004 The module SHALL derive FULL_SIZE = DATA_SIZE + log2(WINDOW) and CH_W = max(1, clog2(NUM_CHANNELS)) as localparams.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port clear, input, 1 bit: synchronous restart of all windows, same effect as reset.
REQ-008 The module SHALL have port input_data, input, DATA_SIZE bits, signed: the sample.
REQ-009 The module SHALL have port enable, input, 1 bit: input_data is valid this cycle.
REQ-010 The module SHALL have port input_ready, output, 1 bit: the sample is accepted when enable && input_ready.
REQ-011 The module SHALL have port output_ready, input, 1 bit: the downstream can take output this cycle.
REQ-012 The module SHALL have port output_data, output, FULL_SIZE bits, signed: the windowed result.
REQ-013 The module SHALL have port output_data_valid, output, 1 bit: output_data and output_channel are valid.
REQ-014 The module SHALL have port output_channel, output, CH_W bits: channel index of output_data.

Function
REQ-015 Accepted samples SHALL be assigned to channels round-robin 0,1,...,NUM_CHANNELS-1,0,... by an internal channel counter that advances only on acceptance.
REQ-016 Each channel SHALL keep a running sum S[c] and a circular delay line of WINDOW samples, each with its own write pointer wrapping from WINDOW-1 to 0.
REQ-017 On acceptance, the update SHALL be S[c] <= S[c] + x - oldest, where oldest is the delay-line entry being overwritten; it is treated as 0 while channel c's fill count is below WINDOW.
REQ-018 Each fill count SHALL saturate at WINDOW; the arithmetic SHALL be sign-extended to FULL_SIZE and can never overflow.
REQ-019 The pipeline SHALL have 2 stages: stage 1 registers the sample and channel, and reads the delay line read-before-write at the write address; stage 2 updates S[c] and loads the output register.
REQ-020 A sample accepted in cycle t SHALL appear with output_data_valid=1 in cycle t+2 if no stall occurs.
REQ-021 The pipeline SHALL use a shared advance signal: advance = !output_data_valid || output_ready, and input_ready = advance, driven combinationally.
REQ-022 While advance=0, all pipeline registers, pointers, sums and output signals SHALL hold.
REQ-023 Back-to-back samples on the same channel (including NUM_CHANNELS=1) SHALL give correct sums every cycle, with no bubbles.
REQ-024 The output SHALL deassert valid only when it is consumed (output_ready=1) and no new result is arriving.

Reset
REQ-025 On reset or clear, the following SHALL be zeroed: the channel counter, write pointers, fill counts, sums, pipeline valids, output_data_valid, output_data and output_channel.
REQ-026 Delay-line contents SHALL not be cleared; the fill counts mask stale data.
REQ-027 A sample presented in the same cycle as reset or clear SHALL be discarded, and in-flight results SHALL be dropped.
REQ-028 If reset is asserted mid-stall, the held output SHALL be discarded.

Configuration
REQ-029 The build SHALL support the macro TEMPLATE_MOVING_AVERAGE_EN.
REQ-030 When TEMPLATE_MOVING_AVERAGE_EN is defined, output_data SHALL be S[c] arithmetically shifted right by log2(WINDOW), rounding toward negative infinity, then sign-extended to FULL_SIZE.
REQ-031 When TEMPLATE_MOVING_AVERAGE_EN is not defined, output_data SHALL be S[c] unmodified.
REQ-032 Latency and handshake SHALL be identical in both builds.

Structure
REQ-033 settings_pkg SHALL hold DATA_SIZE, the default NUM_CHANNELS and WINDOW, and a function computing FULL_SIZE from DATA_SIZE and WINDOW.
REQ-034 The delay lines SHALL live in one sub-module, template_delay_ram: a simple dual-port memory of NUM_CHANNELS*WINDOW x DATA_SIZE, address {channel, pointer}, 1-cycle synchronous read, read-before-write, with a hold (enable) input tied to advance.

Verification
REQ-035 The bench SHALL cover: defaults, output_ready=1, samples 1,2,3,... for all four channels -> channel 0 outputs 1, 1+5=6, ...; once full, each output equals the sum of the last 16 same-channel inputs.
REQ-036 The bench SHALL cover: NUM_CHANNELS=1, WINDOW=4, constant -32768 for 10 cycles -> outputs -32768, -65536, -98304, then -131072 held; no overflow at FULL_SIZE=18.
REQ-037 The bench SHALL cover: output_ready low for 5 cycles with enable high -> input_ready low from the stall's first cycle; output held stable; no sample lost or duplicated after release.
REQ-038 The bench SHALL cover: clear pulsed mid-stream after 7 samples on channel 0 -> the next channel-0 output equals the first post-clear sample only, and the channel counter restarts at 0.
REQ-039 The bench SHALL cover: TEMPLATE_MOVING_AVERAGE_EN defined, WINDOW=4, inputs -1,0,0,0 on one channel -> outputs -1,-1,-1,-1.
REQ-040 The bench SHALL cover: reset during a held output -> output_data_valid=0 the next cycle, and all outputs zero.
